icache_rf_write_arbiter: RTL and testbench
==========================================

ICACHE_RF_WRITE_ARBITER -- requirements
Module: icache_rf_write_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 2, number of write requesters (refill, invalidate, ...).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, register-file address width; NUM_WORDS = 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, register-file word width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  N_REQ  per-requester write request.
REQ-007 req_addr_i  input  N_REQ x ADDR_WIDTH  per-requester write address.
REQ-008 req_wdata_i  input  N_REQ x DATA_WIDTH  per-requester write data.
REQ-009 req_gnt_o  output  N_REQ  one-hot grant; write committed at the edge ending the grant cycle.
REQ-010 flush_req_i  input  1  request to zero every register-file word.
REQ-011 flush_busy_o  output  1  high while the flush sweep runs.
REQ-012 flush_done_o  output  1  one-cycle pulse after the last flush write.
REQ-013 rf_we_o  output  1  register-file write enable.
REQ-014 rf_waddr_o  output  ADDR_WIDTH  register-file write address.
REQ-015 rf_wdata_o  output  DATA_WIDTH  register-file write data.

Function
REQ-016 SHALL implement FSM states ARB and FLUSH; ARB after reset.
REQ-017 In ARB with flush_req_i=0: grant exactly one valid requester per cycle, combinationally; no valid requests -> req_gnt_o=0, rf_we_o=0.
REQ-018 Arbitration SHALL be round-robin: search from priority pointer ptr upward, wrapping at N_REQ; after a grant to i, ptr <= (i+1) mod N_REQ; ptr unchanged when no grant.
REQ-019 On grant to i: rf_we_o=1, rf_waddr_o=req_addr_i[i], rf_wdata_o=req_wdata_i[i], same cycle (zero latency).
REQ-020 Requesters SHALL hold valid, addr and wdata stable until granted; no grant is ever revoked mid-cycle.
REQ-021 In ARB with flush_req_i=1: flush wins, req_gnt_o=0, rf_we_o=0 that cycle, next state FLUSH, sweep counter <= 0.
REQ-022 In FLUSH: rf_we_o=1, rf_waddr_o=counter, rf_wdata_o=0, req_gnt_o=0, flush_busy_o=1; counter increments each cycle.
REQ-023 At counter = NUM_WORDS-1 the write completes, counter wraps to 0, next state ARB; flush_done_o=1 in the first ARB cycle, which also arbitrates normally.
REQ-024 flush_req_i SHALL be ignored while in FLUSH; if still high in the flush_done_o cycle, a new flush starts (flush wins per REQ-021).
REQ-025 Flush of NUM_WORDS words SHALL take exactly NUM_WORDS cycles of rf_we_o; total request-to-done latency NUM_WORDS+1 cycles.
REQ-026 rf_waddr_o and rf_wdata_o SHALL be 0 whenever rf_we_o=0.

Reset
REQ-027 On rst=1 at a clock edge: state <= ARB, ptr <= 0, counter <= 0, regardless of current state (reset mid-flush aborts the sweep, no flush_done_o).
REQ-028 During and after reset until a request: req_gnt_o=0, rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, flush_busy_o=0, flush_done_o=0.

Structure
REQ-029 FSM state enum (ARB, FLUSH) SHALL live in the shared icache package; NUM_WORDS stays a local parameter.
REQ-030 The round-robin arbiter SHALL be one sub-module, icache_rr_arb (valid vector in, one-hot grant out, pointer internal); FSM and sweep counter stay in the top.

Verification (ADDR_WIDTH=5, N_REQ=2)
REQ-031 Reset, idle -> all outputs 0 for 10 cycles.
REQ-032 req_valid_i=2'b11 held for 4 cycles (addr 3/7, data A/B) -> grants 0,1,0,1; rf writes 3:A, 7:B, 3:A, 7:B.
REQ-033 flush_req_i pulse at cycle t -> rf_we_o cycles t+1..t+32, addresses 0..31, data 0; flush_done_o only at t+33; flush_busy_o t+1..t+32.
REQ-034 req_valid_i[0]=1 held from t through a flush starting at t -> no grant t..t+32; grant at t+33 with flush_done_o=1.
REQ-035 rst=1 at flush cycle t+10 -> next cycle ARB, no flush_done_o, ptr=0 (req_valid_i=2'b11 grants requester 0 first).
REQ-036 flush_req_i held high continuously -> back-to-back sweeps, one-cycle ARB gap with flush_done_o=1 and no grant.

Source files
------------

// File: rtl/icache_rf_write_arbiter_pkg.sv
// icache_rf_write_arbiter_pkg: shared icache types for the register-file write arbiter
package icache_rf_write_arbiter_pkg;
  typedef enum logic {ARB, FLUSH} state_t;
endpackage

// File: rtl/icache_rf_write_arbiter_if.sv
// icache_rf_write_arbiter_if: requester, flush and register-file write signals of the arbiter
interface icache_rf_write_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [N_REQ-1:0] req_valid_i;
  logic [N_REQ-1:0][ADDR_WIDTH-1:0] req_addr_i;
  logic [N_REQ-1:0][DATA_WIDTH-1:0] req_wdata_i;
  logic [N_REQ-1:0] req_gnt_o;
  logic flush_req_i;
  logic flush_busy_o;
  logic flush_done_o;
  logic rf_we_o;
  logic [ADDR_WIDTH-1:0] rf_waddr_o;
  logic [DATA_WIDTH-1:0] rf_wdata_o;
  modport master (
    output req_valid_i, req_addr_i, req_wdata_i, flush_req_i,
    input req_gnt_o, flush_busy_o, flush_done_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
  modport slave (
    input req_valid_i, req_addr_i, req_wdata_i, flush_req_i,
    output req_gnt_o, flush_busy_o, flush_done_o, rf_we_o, rf_waddr_o, rf_wdata_o
  );
endinterface

// File: rtl/icache_rr_arb.sv
// icache_rr_arb: round-robin one-hot arbiter; pointer moves past the winner only when a grant is issued
module icache_rr_arb #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] gnt
);
  localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  logic [PW-1:0] ptr, ptr_nxt;
  int j;
  // Scan from farthest to nearest so the requester closest to ptr overrides
  always_comb begin
    gnt = '0;
    ptr_nxt = ptr;
    j = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N_REQ;
      if (en && valid[j]) begin
        gnt = '0;
        gnt[j] = 1'b1;
        ptr_nxt = PW'((j + 1) % N_REQ);
      end
    end
  end
  always_ff @(posedge clk) ptr <= rst ? '0 : ptr_nxt;
endmodule

// File: rtl/icache_rf_write_arbiter.sv
// icache_rf_write_arbiter: arbitrates requester writes into the icache register file and runs a zeroing flush sweep
module icache_rf_write_arbiter
  import icache_rf_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst,
  icache_rf_write_arbiter_if.slave bus
);
  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_WORDS - 1);
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic [N_REQ-1:0] gnt;
  logic done;
  icache_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .en(state == ARB && !bus.flush_req_i),
    .valid(bus.req_valid_i),
    .gnt(gnt)
  );
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    bus.rf_we_o = 1'b0;
    bus.rf_waddr_o = '0;
    bus.rf_wdata_o = '0;
    if (state == FLUSH) begin
      bus.rf_we_o = 1'b1;
      bus.rf_waddr_o = cnt;
      cnt_nxt = cnt + 1'b1;
      state_nxt = cnt == LAST ? ARB : FLUSH;
    end else if (bus.flush_req_i) begin
      state_nxt = FLUSH;
      cnt_nxt = '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (gnt[i]) begin
          bus.rf_we_o = 1'b1;
          bus.rf_waddr_o = bus.req_addr_i[i];
          bus.rf_wdata_o = bus.req_wdata_i[i];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    state <= rst ? ARB : state_nxt;
    cnt <= rst ? '0 : cnt_nxt;
    done <= !rst && state == FLUSH && cnt == LAST;
  end
  assign bus.req_gnt_o = gnt;
  assign bus.flush_busy_o = state == FLUSH;
  assign bus.flush_done_o = done;
endmodule

// File: tb/tb_icache_rf_write_arbiter.sv
// tb_icache_rf_write_arbiter: directed vectors with hand-computed expectations for the rf write arbiter
module tb_icache_rf_write_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  icache_rf_write_arbiter_if #(.N_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();
  icache_rf_write_arbiter #(.N_REQ(2), .ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Fields packed as {gnt, we, waddr, wdata, busy, done}
  task automatic expect_out(input string tag, input logic [1:0] g, input logic we, input logic [4:0] a,
                            input logic [31:0] d, input logic busy, input logic done);
    chk(tag, 64'({bus.req_gnt_o, bus.rf_we_o, bus.rf_waddr_o, bus.rf_wdata_o, bus.flush_busy_o, bus.flush_done_o}),
        64'({g, we, a, d, busy, done}));
  endtask
  task automatic sweep(input string tag, input int n, input logic keep);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.flush_req_i = keep;
      #2 expect_out(tag, 2'b00, 1'b1, 5'(k), 32'h0, 1'b1, 1'b0);
    end
  endtask
  initial begin
    bus.req_valid_i = '0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    bus.flush_req_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #2 expect_out("idle", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_valid_i = 2'b11;
      bus.req_addr_i = {5'd7, 5'd3};
      bus.req_wdata_i = {32'hB, 32'hA};
      #2 if (i % 2 == 0) expect_out("rr_even", 2'b01, 1'b1, 5'd3, 32'hA, 1'b0, 1'b0);
         else expect_out("rr_odd", 2'b10, 1'b1, 5'd7, 32'hB, 1'b0, 1'b0);
    end
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    bus.flush_req_i = 1'b1;
    #2 expect_out("flush_req", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    sweep("flush_sweep", 32, 1'b0);
    @(negedge clk);
    #2 expect_out("flush_done", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #2 expect_out("after_done", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid_i = 2'b01;
    bus.req_addr_i = {5'd7, 5'd9};
    bus.req_wdata_i = {32'hB, 32'hC};
    bus.flush_req_i = 1'b1;
    #2 expect_out("held_req_t", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    sweep("held_sweep", 32, 1'b0);
    @(negedge clk);
    #2 expect_out("held_grant", 2'b01, 1'b1, 5'd9, 32'hC, 1'b0, 1'b1);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #2 expect_out("held_idle", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.flush_req_i = 1'b1;
    #2 expect_out("rst_flush_req", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    sweep("rst_sweep", 9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 2'b11;
    bus.req_addr_i = {5'd7, 5'd3};
    bus.req_wdata_i = {32'hB, 32'hA};
    #2 expect_out("rst_ptr0", 2'b01, 1'b1, 5'd3, 32'hA, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #2 expect_out("rst_no_done", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    bus.req_valid_i = 2'b01;
    bus.req_addr_i = {5'd7, 5'd9};
    bus.req_wdata_i = {32'hB, 32'hC};
    bus.flush_req_i = 1'b1;
    #2 expect_out("b2b_req", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    sweep("b2b_sweep1", 32, 1'b1);
    @(negedge clk);
    #2 expect_out("b2b_gap", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    sweep("b2b_sweep2", 32, 1'b0);
    @(negedge clk);
    #2 expect_out("b2b_grant", 2'b01, 1'b1, 5'd9, 32'hC, 1'b0, 1'b1);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #2 expect_out("final_idle", 2'b00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
